// File: rtl/fpu_divider16_pkg.sv
// rtl/fpu_divider16_pkg.sv - shared widths and FSM state type for the mantissa divider
package fpu_divider16_pkg;

    localparam int FP16_FRACW = 11;
    localparam int QUOTW      = 2 * FP16_FRACW;
    localparam int CNTW       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COMP = 2'd1,
        DONE = 2'd2
    } fpuDivideState_t;

endpackage

// File: rtl/fpu_divider_fsm.sv
// rtl/fpu_divider_fsm.sv - control FSM sequencing the shift-subtract iterations
module fpu_divider_fsm
    import fpu_divider16_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic compDone,
    input  logic zeroDiv,
    output logic compEn,
    output logic done
);

    fpuDivideState_t state_q, state_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // start is deliberately not decoded in COMP so a busy divider ignores it
    always_comb begin
        state_d = state_q;
        compEn  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = COMP;
            end
            COMP: begin
                compEn = 1'b1;
                if (zeroDiv || compDone) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = COMP;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/fpu_divider16.sv
// rtl/fpu_divider16.sv - restoring radix-2 mantissa divider, one quotient bit per cycle
module fpu_divider16
    import fpu_divider16_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [FP16_FRACW-1:0]   divIn1,
    input  logic [FP16_FRACW-1:0]   divIn2,
    output logic [QUOTW-1:0]        quotient,
    output logic [FP16_FRACW-1:0]   remainder,
    output logic                    sticky,
    output logic                    divByZero,
    output logic                    done
);

    logic [QUOTW-1:0]      dividend_q, dividend_d;
    logic [FP16_FRACW-1:0] divisor_q, divisor_d;
    logic [QUOTW-1:0]      quot_q, quot_d;
    logic [FP16_FRACW-1:0] rem_q, rem_d;
    logic                  sticky_q, sticky_d;
    logic                  dbz_q, dbz_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;

    logic                  comp_en;
    logic                  comp_done;
    logic                  zero_div;
    logic                  load;
    logic [FP16_FRACW:0]   partial;
    logic [FP16_FRACW:0]   diff;
    logic [FP16_FRACW:0]   rem_sel;
    logic                  qbit;

    assign zero_div  = (divisor_q == '0);
    assign comp_done = (cnt_q == CNTW'(QUOTW - 1));
    assign load      = start && !comp_en;

    fpu_divider_fsm u_fsm (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .compDone (comp_done),
        .zeroDiv  (zero_div),
        .compEn   (comp_en),
        .done     (done)
    );

    // working remainder stays below the divisor, so one extra bit keeps the compare exact
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        sticky_d   = sticky_q;
        dbz_d      = dbz_q;
        cnt_d      = cnt_q;
        partial    = {rem_q, dividend_q[QUOTW-1]};
        diff       = partial - {1'b0, divisor_q};
        qbit       = (partial >= {1'b0, divisor_q});
        rem_sel    = qbit ? diff : partial;

        if (load) begin
            dividend_d = {divIn1, {FP16_FRACW{1'b0}}};
            divisor_d  = divIn2;
            quot_d     = '0;
            rem_d      = '0;
            sticky_d   = 1'b0;
            dbz_d      = 1'b0;
            cnt_d      = '0;
        end else if (comp_en) begin
            if (zero_div) begin
                quot_d   = '1;
                rem_d    = '0;
                sticky_d = 1'b0;
                dbz_d    = 1'b1;
            end else begin
                rem_d      = rem_sel[FP16_FRACW-1:0];
                sticky_d   = |rem_sel;
                quot_d     = {quot_q[QUOTW-2:0], qbit};
                dividend_d = dividend_q << 1;
                cnt_d      = cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dividend_q <= '0;
            divisor_q  <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            sticky_q   <= 1'b0;
            dbz_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            sticky_q   <= sticky_d;
            dbz_q      <= dbz_d;
            cnt_q      <= cnt_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign sticky    = sticky_q;
    assign divByZero = dbz_q;

endmodule
